bp_be_fp_regfile_cfg_master: RTL

Initiator side of the FP register file configuration access path. It accepts single-register read/write requests from the host or debug config unit over a valid/ready interface and drives the regfile's frf_r_v / frf_w_v / frf_addr / frf_data strobes. For reads, it captures the synchronous read data one cycle later and returns a response over a valid/yumi interface. It sits in bp_be_calculator beside the FP regfile and issues only when the FP pipeline reports no writeback can collide.

---
 rtl/bp_be_fp_regfile_cfg_master.sv | 114 +++++++++++
 1 files changed

// File: rtl/bp_be_fp_regfile_cfg_master.sv
// Purpose: config-path initiator for the FP regfile. It takes one read or write at a time and strobes the regfile.
// Latency: the strobe fires 1 cycle after accept. A write response follows 1 cycle later. A read response follows 2 cycles later.
// Backpressure: the strobe waits while pipe_idle_i is low. The response is held until resp_yumi_i. No new request is taken until then.
//
// Ports:
//   clk_i, reset_i                 clock, synchronous active-high reset
//   req_v_i/req_ready_o            request handshake (req_w_i, req_addr_i, req_data_i)
//   pipe_idle_i                    FP pipe has no writeback that could collide
//   busy_o                         a request is held; issue stage stalls FP ops
//   frf_r_v_o/frf_w_v_o            one-cycle regfile strobes (frf_addr_o, frf_data_o)
//   cfg_data_i                     regfile read data, valid the cycle after frf_r_v_o
//   resp_v_o/resp_yumi_i           response handshake (resp_data_o, 0 for writes)
module bp_be_fp_regfile_cfg_master #(
    parameter int reg_addr_width_p = 5,
    parameter int dword_width_p    = 64
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        req_v_i,
    output logic                        req_ready_o,
    input  logic                        req_w_i,
    input  logic [reg_addr_width_p-1:0] req_addr_i,
    input  logic [dword_width_p-1:0]    req_data_i,
    input  logic                        pipe_idle_i,
    output logic                        busy_o,
    output logic                        frf_r_v_o,
    output logic                        frf_w_v_o,
    output logic [reg_addr_width_p-1:0] frf_addr_o,
    output logic [dword_width_p-1:0]    frf_data_o,
    input  logic [dword_width_p-1:0]    cfg_data_i,
    output logic                        resp_v_o,
    output logic [dword_width_p-1:0]    resp_data_o,
    input  logic                        resp_yumi_i
);

    localparam logic [1:0] e_idle    = 2'd0;
    localparam logic [1:0] e_issue   = 2'd1;
    localparam logic [1:0] e_capture = 2'd2;
    localparam logic [1:0] e_resp    = 2'd3;

    logic [1:0]                  state_q, state_d;
    logic                        w_q, w_d;
    logic [reg_addr_width_p-1:0] addr_q, addr_d;
    logic [dword_width_p-1:0]    data_q, data_d;
    logic [dword_width_p-1:0]    resp_data_q, resp_data_d;
    logic                        req_hs;
    logic                        issue;

    assign req_ready_o = (state_q == e_idle) & ~reset_i;
    assign req_hs      = req_v_i & req_ready_o;
    // Gating with reset keeps a stalled request from leaking a strobe
    // in the same cycle that it is being dropped.
    assign issue       = (state_q == e_issue) & pipe_idle_i & ~reset_i;

    always_comb begin
        state_d     = state_q;
        w_d         = w_q;
        addr_d      = addr_q;
        data_d      = data_q;
        resp_data_d = resp_data_q;
        case (state_q)
            e_idle: begin
                if (req_hs) begin
                    w_d         = req_w_i;
                    addr_d      = req_addr_i;
                    data_d      = req_data_i;
                    // A write response carries zero, so clear any stale read data.
                    resp_data_d = '0;
                    state_d     = e_issue;
                end
            end
            e_issue: begin
                if (issue) begin
                    state_d = w_q ? e_resp : e_capture;
                end
            end
            e_capture: begin
                resp_data_d = cfg_data_i;
                state_d     = e_resp;
            end
            e_resp: begin
                if (resp_yumi_i) begin
                    state_d = e_idle;
                end
            end
            default: state_d = e_idle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= e_idle;
            w_q         <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            w_q         <= w_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            resp_data_q <= resp_data_d;
        end
    end

    assign busy_o      = (state_q != e_idle);
    assign frf_w_v_o   = issue & w_q;
    assign frf_r_v_o   = issue & ~w_q;
    assign frf_addr_o  = addr_q;
    assign frf_data_o  = data_q;
    assign resp_v_o    = (state_q == e_resp);
    assign resp_data_o = resp_v_o ? resp_data_q : '0;

endmodule
